sdram_port_arb: RTL and testbench
=================================

# sdram_port_arb

Arbitrates the single SDRAM command port between the scene loader's write stream and a read requester from the ray pipeline (e.g. scene fetch). Scene-loader writes arrive as single-cycle pulses with no backpressure, so they are buffered in a small FIFO. The block issues one request at a time to the SDRAM controller using a req/ack handshake, with a starvation bound on reads.

## Interface
- FIFO_DEPTH, 4: scene-loader write buffer entries; power of two, at least 2.
- MAX_WAIT, 8: consecutive write grants allowed while a read is pending; 1 to 255.

- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- sl_addr  in  25  scene-loader write word address
- sl_io  in  32  scene-loader write data
- sl_we  in  1  single-cycle write pulse
- rd_req  in  1  read request level; hold until rd_gnt
- rd_addr  in  25  read address; stable while rd_req is high
- rd_gnt  out  1  one-cycle pulse: read accepted by the controller
- mem_req  out  1  request to the SDRAM controller (registered)
- mem_we  out  1  1 = write, 0 = read (registered)
- mem_addr  out  25  registered address
- mem_wdata  out  32  registered write data; 0 for reads
- mem_ack  in  1  controller accepts the current request this cycle
- wr_pending  out  1  FIFO non-empty or a write is in flight
- sl_ovf  out  1  sticky: a scene-loader write was dropped

## Operation
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_gnt=0, sl_ovf=0, wr_pending=0; FIFO empty; wait_cnt=0; state IDLE.
- FIFO: push {sl_addr, sl_io} on sl_we.
  - Push when full with no pop: entry dropped, sl_ovf set (cleared only by reset).
  - Push and pop in the same cycle when full: accepted, occupancy unchanged.
- State machine IDLE, ISSUE_WR, ISSUE_RD.
- IDLE:
  - If the FIFO is non-empty and (rd_req=0 or wait_cnt<MAX_WAIT): pop the head into the mem_* registers, set mem_we=1 and mem_req=1, go to ISSUE_WR.
  - Otherwise, if rd_req=1: load rd_addr, set mem_we=0, mem_wdata=0, mem_req=1, go to ISSUE_RD.
  - Otherwise stay in IDLE.
- ISSUE_WR / ISSUE_RD:
  - Hold mem_* stable until mem_ack.
  - On mem_ack: mem_req=0 next cycle and return to IDLE.
  - In ISSUE_RD, rd_gnt pulses in the cycle after mem_ack.
- wait_cnt (8 bits):
  - Increments on each write issue while rd_req=1.
  - Clears on read issue, and whenever rd_req=0 in IDLE.
  - Saturates at MAX_WAIT.
- FIFO bypass: an sl_we arriving with the FIFO empty is pushed first and issued no earlier than the next cycle.
- Reset mid-operation: any in-flight request is abandoned, FIFO contents are lost, and mem_req drops immediately.

## Timing
- Write latency: sl_we at cycle T into an empty FIFO, state IDLE → mem_req=1 at T+2. With mem_ack at T+2, mem_req=0 at T+3.
- Read latency: rd_req at T in IDLE with the FIFO empty → mem_req=1 at T+1. mem_ack at cycle A → rd_gnt high at A+1.
- Maximum throughput: one request per 2 cycles (issue, then IDLE).
- mem_ack while mem_req=0 is ignored.
- wr_pending = FIFO non-empty OR state == ISSUE_WR. It is combinational from registered state.

## Configuration
- SDRAM_ARB_PERF_EN defined: adds outputs wr_cnt[15:0] and rd_cnt[15:0].
  - Each counts acked requests of its type.
  - Both wrap at 16'hFFFF→0 and reset to 0.
  - Adds rd_stall_max[7:0]: the peak wait_cnt seen.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

## Structure
- Package sdram_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, ISSUE_WR, ISSUE_RD} arb_state_t;
  - typedef struct packed {logic [24:0] addr; logic [31:0] data;} sl_wr_t;
  - localparams SDRAM_AW=25, SDRAM_DW=32.
- One sub-module: sl_wr_fifo, a synchronous FIFO of sl_wr_t with push, pop, full, empty and head outputs, using the same clk and rst.

## Test plan
- Reset, then one write: sl_we with addr 25'h0000123 and data 32'hDEADBEEF → two cycles later mem_req=1, mem_we=1 with matching addr/data. After mem_ack, mem_req=0 and wr_pending=0.
- Read only: rd_req with rd_addr 25'h1ABCDEF, mem_ack 3 cycles after mem_req → rd_gnt pulses exactly once, one cycle after mem_ack. mem_wdata=0.
- Overflow: FIFO_DEPTH=4, mem_ack held low, 6 sl_we pulses → 1 issued, 4 buffered, 1 dropped, sl_ovf=1. After acks, exactly 5 writes appear in order.
- Starvation bound: MAX_WAIT=8, FIFO kept non-empty, rd_req held high → exactly 8 write issues, then a read issue, then wait_cnt=0.
- Simultaneous full push+pop: FIFO full, sl_we in the same cycle as the IDLE pop → no drop, sl_ovf stays 0.
- Async reset during ISSUE_WR: assert rst mid-request → mem_req=0 immediately, FIFO empty, sl_ovf=0. Under SDRAM_ARB_PERF_EN, the counters read 0.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the SDRAM command-port arbiter.
package sdram_arb_pkg;

  localparam int SDRAM_AW = 25;
  localparam int SDRAM_DW = 32;

  typedef enum logic [1:0] {IDLE, ISSUE_WR, ISSUE_RD} arb_state_t;

  typedef struct packed {
    logic [SDRAM_AW-1:0] addr;
    logic [SDRAM_DW-1:0] data;
  } sl_wr_t;

endpackage

// File: rtl/sl_wr_fifo.sv
// Synchronous FIFO buffering scene-loader writes. A push while full is
// accepted only when a pop happens in the same cycle; otherwise the caller
// sees it as dropped.
module sl_wr_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  sl_wr_t push_data,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output sl_wr_t head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  sl_wr_t      mem [DEPTH];
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[PW-1:0]];

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write.
  // NOTE: the storage array is not reset; the pointers alone define which
  // entries are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/sdram_port_arb.sv
// Arbitrates the SDRAM command port between buffered scene-loader writes
// and a level-held read request, with a bound on how many writes may pass
// a waiting read. Optional perf counters under SDRAM_ARB_PERF_EN.
module sdram_port_arb
  import sdram_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SDRAM_AW-1:0] sl_addr,
  input  logic [SDRAM_DW-1:0] sl_io,
  input  logic                sl_we,
  input  logic                rd_req,
  input  logic [SDRAM_AW-1:0] rd_addr,
  output logic                rd_gnt,
  output logic                mem_req,
  output logic                mem_we,
  output logic [SDRAM_AW-1:0] mem_addr,
  output logic [SDRAM_DW-1:0] mem_wdata,
  input  logic                mem_ack,
  output logic                wr_pending,
  output logic                sl_ovf
`ifdef SDRAM_ARB_PERF_EN
  ,
  output logic [15:0]         wr_cnt,
  output logic [15:0]         rd_cnt,
  output logic [7:0]          rd_stall_max
`endif
);

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  arb_state_t          state, state_d;
  logic [7:0]          wait_cnt, wait_d;
  logic                req_d, we_d, gnt_d;
  logic [SDRAM_AW-1:0] addr_d;
  logic [SDRAM_DW-1:0] wdata_d;
  logic                pop, full, empty;
  sl_wr_t              head;

  sl_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (sl_we),
    .push_data ('{addr: sl_addr, data: sl_io}),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  assign wr_pending = !empty || (state == ISSUE_WR);

  // Next-state, issue decision and starvation counter.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state;
    req_d   = mem_req;
    we_d    = mem_we;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    gnt_d   = 1'b0;
    wait_d  = wait_cnt;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && (!rd_req || wait_cnt < MAX_W)) begin
          pop     = 1'b1;
          addr_d  = head.addr;
          wdata_d = head.data;
          we_d    = 1'b1;
          req_d   = 1'b1;
          state_d = ISSUE_WR;
          if (rd_req) wait_d = (wait_cnt < MAX_W) ? wait_cnt + 8'd1 : wait_cnt;
          else        wait_d = 8'd0;
        end else if (rd_req) begin
          addr_d  = rd_addr;
          wdata_d = '0;
          we_d    = 1'b0;
          req_d   = 1'b1;
          state_d = ISSUE_RD;
          wait_d  = 8'd0;
        end else begin
          wait_d = 8'd0;
        end
      end
      ISSUE_WR, ISSUE_RD: begin
        if (mem_req && mem_ack) begin
          req_d   = 1'b0;
          gnt_d   = (state == ISSUE_RD);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered command port, state and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_gnt    <= 1'b0;
      sl_ovf    <= 1'b0;
    end else begin
      state     <= state_d;
      wait_cnt  <= wait_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      rd_gnt    <= gnt_d;
      if (sl_we && full && !pop) sl_ovf <= 1'b1;
    end
  end

`ifdef SDRAM_ARB_PERF_EN
  // Acked-request counters (wrapping) and peak read wait.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt       <= 16'd0;
      rd_cnt       <= 16'd0;
      rd_stall_max <= 8'd0;
    end else begin
      if (mem_req && mem_ack && state == ISSUE_WR) wr_cnt <= wr_cnt + 16'd1;
      if (mem_req && mem_ack && state == ISSUE_RD) rd_cnt <= rd_cnt + 16'd1;
      if (wait_cnt > rd_stall_max) rd_stall_max <= wait_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed self-checking bench for sdram_port_arb (FIFO_DEPTH=4, MAX_WAIT=8).
module tb_sdram_port_arb;
  import sdram_arb_pkg::*;

  logic        clk, rst, sl_we, rd_req, rd_gnt, mem_req, mem_we, mem_ack;
  logic        wr_pending, sl_ovf;
  logic [24:0] sl_addr, rd_addr, mem_addr;
  logic [31:0] sl_io, mem_wdata;
`ifdef SDRAM_ARB_PERF_EN
  logic [15:0] wr_cnt, rd_cnt;
  logic [7:0]  rd_stall_max;
`endif

  int checks = 0;
  int errors = 0;

  sdram_port_arb #(.FIFO_DEPTH(4), .MAX_WAIT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .sl_addr    (sl_addr),
    .sl_io      (sl_io),
    .sl_we      (sl_we),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_gnt     (rd_gnt),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .wr_pending (wr_pending),
    .sl_ovf     (sl_ovf)
`ifdef SDRAM_ARB_PERF_EN
    ,
    .wr_cnt       (wr_cnt),
    .rd_cnt       (rd_cnt),
    .rd_stall_max (rd_stall_max)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, 64'(mem_req), 64'h1);
  endtask

  task automatic drive_push(input logic [24:0] a, input logic [31:0] d);
    sl_we   = 1'b1;
    sl_addr = a;
    sl_io   = d;
    tick();
    sl_we   = 1'b0;
  endtask

  task automatic ack_one();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tick();
  endtask

  initial begin
    int gnt_seen;
    int nwr;
    int nxt;
    bit seen_rd;

    rst = 1'b0; sl_we = 1'b0; sl_addr = '0; sl_io = '0;
    rd_req = 1'b0; rd_addr = '0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values
    check("rst_mem_req",    64'(mem_req),    64'h0);
    check("rst_mem_we",     64'(mem_we),     64'h0);
    check("rst_mem_addr",   64'(mem_addr),   64'h0);
    check("rst_mem_wdata",  64'(mem_wdata),  64'h0);
    check("rst_rd_gnt",     64'(rd_gnt),     64'h0);
    check("rst_sl_ovf",     64'(sl_ovf),     64'h0);
    check("rst_wr_pending", 64'(wr_pending), 64'h0);
    rst = 1'b1;
    tick();

    // Single write: issued two cycles after the pulse
    drive_push(25'h0000123, 32'hDEADBEEF);
    check("wr_t1_req",     64'(mem_req),    64'h0);
    check("wr_t1_pending", 64'(wr_pending), 64'h1);
    tick();
    check("wr_t2_req",   64'(mem_req),   64'h1);
    check("wr_t2_we",    64'(mem_we),    64'h1);
    check("wr_t2_addr",  64'(mem_addr),  64'h0000123);
    check("wr_t2_wdata", 64'(mem_wdata), 64'hDEADBEEF);
    ack_one();
    check("wr_t3_req",     64'(mem_req),    64'h0);
    check("wr_t3_pending", 64'(wr_pending), 64'h0);

    // Read only: ack three cycles after mem_req, single rd_gnt pulse
    rd_req  = 1'b1;
    rd_addr = 25'h1ABCDEF;
    tick();
    check("rd_req",   64'(mem_req),   64'h1);
    check("rd_we",    64'(mem_we),    64'h0);
    check("rd_addr",  64'(mem_addr),  64'h1ABCDEF);
    check("rd_wdata", 64'(mem_wdata), 64'h0);
    gnt_seen = 0;
    repeat (3) begin
      tick();
      gnt_seen += int'(rd_gnt);
    end
    check("rd_hold_req",  64'(mem_req),  64'h1);
    check("rd_hold_addr", 64'(mem_addr), 64'h1ABCDEF);
    ack_one();
    check("rd_gnt_pulse", 64'(rd_gnt),  64'h1);
    check("rd_req_drop",  64'(mem_req), 64'h0);
    gnt_seen += int'(rd_gnt);
    rd_req = 1'b0;
    repeat (3) begin
      tick();
      gnt_seen += int'(rd_gnt);
    end
    check("rd_gnt_count", 64'(gnt_seen), 64'h1);
    check("rd_no_reissue", 64'(mem_req), 64'h0);

    // Overflow: six pulses, ack held low -> 1 issued, 4 buffered, 1 dropped
    for (int i = 0; i < 6; i++) drive_push(25'h100 + 25'(i), 32'hA000_0000 + 32'(i));
    check("ovf_flag",  64'(sl_ovf),   64'h1);
    check("ovf_issue", 64'(mem_addr), 64'h100);
    for (int k = 0; k < 5; k++) begin
      wait_req("ovf_drain_req");
      check("ovf_drain_addr",  64'(mem_addr),  64'h100 + 64'(k));
      check("ovf_drain_wdata", 64'(mem_wdata), 64'hA000_0000 + 64'(k));
      ack_one();
    end
    repeat (3) tick();
    check("ovf_no_sixth", 64'(mem_req),    64'h0);
    check("ovf_empty",    64'(wr_pending), 64'h0);
    check("ovf_sticky",   64'(sl_ovf),     64'h1);
`ifdef SDRAM_ARB_PERF_EN
    check("perf_wr_cnt", 64'(wr_cnt), 64'd6);
    check("perf_rd_cnt", 64'(rd_cnt), 64'd1);
`endif

    // Starvation bound; refills happen on full-FIFO pop cycles, so the
    // simultaneous push+pop at full is exercised and must not drop.
    do_reset();
    for (int i = 0; i < 5; i++) drive_push(25'h200 + 25'(i), 32'(i));
    check("stv_w0", 64'(mem_wdata), 64'h0);
    rd_req  = 1'b1;
    rd_addr = 25'h0F0F0F0;
    ack_one();
    nxt = 5;
    sl_we = 1'b1; sl_addr = 25'h200 + 25'(nxt); sl_io = 32'(nxt); nxt++;
    tick();
    sl_we = 1'b0;
    nwr = 0;
    seen_rd = 1'b0;
    for (int i = 0; i < 12 && !seen_rd; i++) begin
      wait_req("stv_req");
      if (mem_we) begin
        nwr++;
        check("stv_wr_data", 64'(mem_wdata), 64'(nwr));
        ack_one();
        if (nwr < 8) begin
          sl_we = 1'b1; sl_addr = 25'h200 + 25'(nxt); sl_io = 32'(nxt); nxt++;
          tick();
          sl_we = 1'b0;
        end
      end else begin
        seen_rd = 1'b1;
      end
    end
    check("stv_wr_count", 64'(nwr),      64'd8);
    check("stv_rd_seen",  64'(seen_rd),  64'h1);
    check("stv_rd_addr",  64'(mem_addr), 64'h0F0F0F0);
    check("stv_wait_clr", 64'(dut.wait_cnt), 64'h0);
    check("full_pushpop_no_ovf", 64'(sl_ovf), 64'h0);
`ifdef SDRAM_ARB_PERF_EN
    check("perf_stall_max", 64'(rd_stall_max), 64'd8);
`endif
    ack_one();
    check("stv_rd_gnt", 64'(rd_gnt), 64'h1);
    rd_req = 1'b0;
    for (int k = 9; k < 13; k++) begin
      wait_req("stv_drain_req");
      check("stv_drain_data", 64'(mem_wdata), 64'(k));
      ack_one();
    end
    tick();
    check("stv_empty", 64'(wr_pending), 64'h0);

    // Async reset mid ISSUE_WR with a full FIFO and overflow flagged
    for (int i = 0; i < 6; i++) drive_push(25'h300 + 25'(i), 32'hC000_0000 + 32'(i));
    check("ar_pre_req", 64'(mem_req), 64'h1);
    check("ar_pre_ovf", 64'(sl_ovf),  64'h1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_req",     64'(mem_req),    64'h0);
    check("ar_we",      64'(mem_we),     64'h0);
    check("ar_pending", 64'(wr_pending), 64'h0);
    check("ar_ovf",     64'(sl_ovf),     64'h0);
`ifdef SDRAM_ARB_PERF_EN
    check("ar_wr_cnt",    64'(wr_cnt),       64'h0);
    check("ar_rd_cnt",    64'(rd_cnt),       64'h0);
    check("ar_stall_max", 64'(rd_stall_max), 64'h0);
`endif
    rst = 1'b1;
    repeat (3) tick();
    check("ar_post_idle", 64'(mem_req), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
